axis_packet_fifo: RTL and testbench

//  - Parametrised AXI4-Stream FIFO; successor to the fixed-depth AXIS FIFO.
//  - Adds configurable depth, TLAST/TUSER carriage, occupancy count, almost-full/empty flags and synchronous flush.
//  - Optional store-and-forward packet mode.
//  - Sits between an AXIS source (e.g. hex-driven bench source) and any AXIS sink.

---
 rtl/axis_packet_fifo_if.sv | 14 +
 rtl/axis_packet_fifo.sv | 109 ++++++++++
 tb/tb_axis_packet_fifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_packet_fifo_if.sv
// AXI4-Stream beat bundle shared by the FIFO's write side (slave) and read side (master).
interface axis_packet_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_packet_fifo.sv
// Parametrised AXI4-Stream FIFO carrying tdata/tuser/tlast with occupancy count, flags and flush.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward packet mode; cut-through otherwise.
module axis_packet_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int USER_WIDTH   = 1,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 2**ADDR_WIDTH,
    parameter int ALMOST_FULL  = DEPTH - 4,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    axis_packet_fifo_if.slave     in_axis,
    axis_packet_fifo_if.master    out_axis,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);
    localparam int ENTRY_W = DATA_WIDTH + USER_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_EMPTY);

    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wrPtr;
    logic [ADDR_WIDTH-1:0] r_rdPtr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ENTRY_W-1:0]    w_rdEntry;
    logic                  w_inReady;
    logic                  w_outValid;
    logic                  w_write;
    logic                  w_read;

    // A read in the same cycle never frees a slot for a write while full.
    assign w_inReady = !reset && !flush && (r_count != FULL_COUNT);
    assign w_write   = in_axis.tvalid && w_inReady;
    assign w_read    = w_outValid && out_axis.tready;

    assign in_axis.tready  = w_inReady;
    assign out_axis.tvalid = w_outValid;
    assign w_rdEntry       = r_mem[r_rdPtr];
    assign {out_axis.tlast, out_axis.tuser, out_axis.tdata} = w_rdEntry;

    assign count        = r_count;
    assign almost_full  = (r_count >= AF_LEVEL);
    assign almost_empty = (r_count <= AE_LEVEL);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= {in_axis.tlast, in_axis.tuser, in_axis.tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_read) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [ADDR_WIDTH:0] r_pktCount;
    logic                r_cutThrough;
    logic                w_oversize;
    logic                w_wrLast;
    logic                w_rdLast;

    // A packet larger than the FIFO would never complete, so fall back to cut-through.
    assign w_oversize = (r_count == FULL_COUNT) && (r_pktCount == '0);
    assign w_wrLast   = w_write && in_axis.tlast;
    assign w_rdLast   = w_read && w_rdEntry[ENTRY_W-1];
    assign w_outValid = (r_count != '0) && ((r_pktCount != '0) || r_cutThrough || w_oversize);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_pktCount   <= '0;
            r_cutThrough <= 1'b0;
        end else begin
            case ({w_wrLast, w_rdLast})
                2'b10:   r_pktCount <= r_pktCount + 1'b1;
                2'b01:   r_pktCount <= r_pktCount - 1'b1;
                default: r_pktCount <= r_pktCount;
            endcase
            if (w_rdLast) begin
                r_cutThrough <= 1'b0;
            end else if (w_oversize) begin
                r_cutThrough <= 1'b1;
            end
        end
    end
`else
    assign w_outValid = (r_count != '0);
`endif

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Scoreboard bench for axis_packet_fifo: directed writes push expected beats, a forked monitor pops and compares.
// Default build runs cut-through tests; with AXIS_FIFO_PACKET_MODE_EN it runs the packet-mode tests on a 16-deep FIFO.
module tb_axis_packet_fifo;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    localparam int AW = 4;
`else
    localparam int AW = 8;
`endif
    localparam int DEPTH = 2**AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [AW:0] count;
    logic        almostFull;
    logic        almostEmpty;

    int checks   = 0;
    int failures = 0;
    logic [17:0] expQ [$];

    axis_packet_fifo_if #(.DATA_WIDTH(16), .USER_WIDTH(1)) inAxis ();
    axis_packet_fifo_if #(.DATA_WIDTH(16), .USER_WIDTH(1)) outAxis ();

    axis_packet_fifo #(.DATA_WIDTH(16), .USER_WIDTH(1), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_axis      (inAxis),
        .out_axis     (outAxis),
        .count        (count),
        .almost_full  (almostFull),
        .almost_empty (almostEmpty)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete, expected finish before 2 ms");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat once the FIFO can take it, and record it as expected output
    task automatic applyStimulus(input logic [15:0] data, input logic user, input logic last);
        int guard = 0;
        while (!inAxis.tready && guard < 64) begin
            tick();
            guard++;
        end
        if (!inAxis.tready) begin
            checkOutput("tready_timeout", 32'(inAxis.tready), 1);
        end
        inAxis.tvalid = 1'b1;
        inAxis.tdata  = data;
        inAxis.tuser  = user;
        inAxis.tlast  = last;
        expQ.push_back({last, user, data});
        tick();
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (expQ.size() != 0 && guard < 1000) begin
            tick();
            guard++;
        end
        checkOutput("drain_left", 32'(expQ.size()), 0);
    endtask

    // Compare every accepted output beat against the head of the scoreboard
    task automatic monitor();
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && outAxis.tvalid && outAxis.tready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_beat: got 0x%0h expected no beat",
                             {outAxis.tlast, outAxis.tuser, outAxis.tdata});
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat", 32'({outAxis.tlast, outAxis.tuser, outAxis.tdata}), 32'(e));
                end
            end
        end
    endtask

    initial begin
        int n;
        int expCount;
        fork
            monitor();
        join_none

        reset          = 1'b1;
        flush          = 1'b0;
        inAxis.tvalid  = 1'b0;
        inAxis.tdata   = '0;
        inAxis.tuser   = '0;
        inAxis.tlast   = 1'b0;
        outAxis.tready = 1'b0;
        repeat (2) tick();

        $display("[TB] reset state");
        checkOutput("rst_in_tready", 32'(inAxis.tready), 0);
        checkOutput("rst_out_tvalid", 32'(outAxis.tvalid), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_almost_empty", 32'(almostEmpty), 1);
        checkOutput("rst_almost_full", 32'(almostFull), 0);
        reset = 1'b0;
        #1;
        checkOutput("rel_in_tready", 32'(inAxis.tready), 1);

`ifndef AXIS_FIFO_PACKET_MODE_EN
        $display("[TB] streaming 0x0001..0x0010");
        outAxis.tready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(16'(k), 1'(k & 1), (k == 16));
            checkOutput("t1_count", 32'(count), 1);
            checkOutput("t1_out_tvalid", 32'(outAxis.tvalid), 1);
        end
        inAxis.tvalid = 1'b0;
        tick();
        checkOutput("t1_count_end", 32'(count), 0);
        waitDrain();

        $display("[TB] fill to full");
        outAxis.tready = 1'b0;
        n = 0;
        while (inAxis.tready && n < DEPTH + 8) begin
            inAxis.tvalid = 1'b1;
            inAxis.tdata  = 16'(32'h1000 + n);
            inAxis.tuser  = 1'b0;
            inAxis.tlast  = 1'b0;
            expQ.push_back({1'b0, 1'b0, 16'(32'h1000 + n)});
            tick();
            n++;
            checkOutput("t2_count", 32'(count), 32'(n));
            if (n == DEPTH - 5) checkOutput("t2_af_below", 32'(almostFull), 0);
            if (n == DEPTH - 4) checkOutput("t2_af_at", 32'(almostFull), 1);
        end
        checkOutput("t2_accepted", 32'(n), 32'(DEPTH));
        checkOutput("t2_full_tready", 32'(inAxis.tready), 0);

        $display("[TB] write and read while full");
        inAxis.tvalid  = 1'b1;
        inAxis.tdata   = 16'hAAAA;
        inAxis.tuser   = 1'b1;
        inAxis.tlast   = 1'b0;
        outAxis.tready = 1'b1;
        tick();
        checkOutput("t3_count_after_full", 32'(count), 32'(DEPTH - 1));
        checkOutput("t3_tready_after_full", 32'(inAxis.tready), 1);
        expQ.push_back({1'b0, 1'b1, 16'hAAAA});
        tick();
        checkOutput("t3_count_rw", 32'(count), 32'(DEPTH - 1));
        inAxis.tvalid = 1'b0;
        expCount = DEPTH - 1;
        while (expCount > 0) begin
            tick();
            expCount--;
            checkOutput("t3_drain_count", 32'(count), 32'(expCount));
            if (expCount == 5) checkOutput("t3_ae_above", 32'(almostEmpty), 0);
            if (expCount == 4) checkOutput("t3_ae_at", 32'(almostEmpty), 1);
        end
        waitDrain();

        $display("[TB] flush with 37 entries");
        outAxis.tready = 1'b0;
        for (int k = 0; k < 37; k++) begin
            applyStimulus(16'(32'h2000 + k), 1'b0, 1'b0);
        end
        inAxis.tvalid = 1'b0;
        checkOutput("t4_count_before", 32'(count), 37);
        flush         = 1'b1;
        inAxis.tvalid = 1'b1;
        inAxis.tdata  = 16'hDEAD;
        #1;
        checkOutput("t4_tready_flush", 32'(inAxis.tready), 0);
        tick();
        flush         = 1'b0;
        inAxis.tvalid = 1'b0;
        #1;
        checkOutput("t4_count_after", 32'(count), 0);
        checkOutput("t4_out_tvalid_after", 32'(outAxis.tvalid), 0);
        checkOutput("t4_tready_after", 32'(inAxis.tready), 1);
        expQ.delete();
        outAxis.tready = 1'b1;
        applyStimulus(16'h0500, 1'b0, 1'b0);
        applyStimulus(16'h0501, 1'b0, 1'b1);
        inAxis.tvalid = 1'b0;
        waitDrain();
        tick();
        checkOutput("t4_count_end", 32'(count), 0);
`else
        $display("[TB] packet mode: 5-beat packet");
        outAxis.tready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(16'(32'h0050 + k), 1'b0, (k == 5));
            checkOutput("t5_out_tvalid", 32'(outAxis.tvalid), (k == 5) ? 1 : 0);
        end
        inAxis.tvalid = 1'b0;
        waitDrain();
        checkOutput("t5_count_end", 32'(count), 0);

        $display("[TB] packet mode: 20-beat oversize packet");
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(16'(32'h0600 + k), 1'b1, (k == 20));
            if (k == DEPTH - 1) checkOutput("t6_held", 32'(outAxis.tvalid), 0);
            if (k == DEPTH) begin
                checkOutput("t6_forced_valid", 32'(outAxis.tvalid), 1);
                checkOutput("t6_count_full", 32'(count), 32'(DEPTH));
            end
        end
        inAxis.tvalid = 1'b0;
        waitDrain();
        tick();
        checkOutput("t6_count_end", 32'(count), 0);
        checkOutput("t6_out_tvalid_end", 32'(outAxis.tvalid), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
